// File: rtl/rf_arbiter.sv
// Round-robin arbiter sharing one single-port register file between a command
// controller (requester 0) and an auxiliary config/debug master (requester 1).
// Grants are combinational. RF strobes and read returns appear one cycle after the transfer edge.
// A requester holds REQx until GNTx. Grants are blocked while a read is outstanding.
//
// Ports:
//   CLK, RST (async, active-low)
//   REQx/WRx/ADDRx/WDATAx -> GNTx                  requester side, x = 0/1
//   RDATAx/RVALIDx/RERRx                           registered read return; RERR marks a timeout
//   RF_WrEn/RF_RdEn/RF_Address/RF_Wr_D/RF_Rd_D/RF_Rd_D_Valid   register-file side
module rf_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR0,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic              RERR0,
    output logic              RERR1,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [DATA_W-1:0] RF_Wr_D,
    input  logic [DATA_W-1:0] RF_Rd_D,
    input  logic              RF_Rd_D_Valid
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // The counter is 0 in the first RD_WAIT cycle. Aborting on TIMEOUT-1 therefore
    // bounds the time spent in RD_WAIT to exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic              last_q;    // requester granted most recently
    logic              owner_q;   // requester that owns the outstanding read
    logic [7:0]        cnt_q;

    logic              gnt0;
    logic              gnt1;
    logic              xfer;
    logic              xfer_id;
    logic              xfer_wr;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;
    logic              rd_done;
    logic              rd_abort;
    logic [DATA_W-1:0] ret_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rd_done  = 1'b0;
        rd_abort = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by RST so no grant is shown while reset is held.
                if (RST) begin
                    gnt0 = REQ0 && (!REQ1 || last_q);
                    gnt1 = REQ1 && (!REQ0 || !last_q);
                    if ((gnt0 && !WR0) || (gnt1 && !WR1)) begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Valid data takes priority over a timeout in the same cycle.
                if (RF_Rd_D_Valid) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_abort = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign GNT0       = gnt0;
    assign GNT1       = gnt1;
    assign xfer       = gnt0 || gnt1;
    assign xfer_id    = gnt1;
    assign xfer_wr    = gnt1 ? WR1 : WR0;
    assign xfer_addr  = gnt1 ? ADDR1 : ADDR0;
    assign xfer_wdata = gnt1 ? WDATA1 : WDATA0;
    assign ret_data   = rd_done ? RF_Rd_D : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_Wr_D    <= '0;
            RDATA0     <= '0;
            RDATA1     <= '0;
            RVALID0    <= 1'b0;
            RVALID1    <= 1'b0;
            RERR0      <= 1'b0;
            RERR1      <= 1'b0;
        end else begin
            RF_WrEn <= xfer && xfer_wr;
            RF_RdEn <= xfer && !xfer_wr;
            RVALID0 <= (rd_done || rd_abort) && !owner_q;
            RVALID1 <= (rd_done || rd_abort) && owner_q;
            RERR0   <= rd_abort && !owner_q;
            RERR1   <= rd_abort && owner_q;

            if (xfer) begin
                last_q     <= xfer_id;
                RF_Address <= xfer_addr;
                if (xfer_wr) begin
                    RF_Wr_D <= xfer_wdata;
                end else begin
                    owner_q <= xfer_id;
                    cnt_q   <= '0;
                end
            end

            if (state_q == RD_WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (rd_done || rd_abort) begin
                if (owner_q) begin
                    RDATA1 <= ret_data;
                end else begin
                    RDATA0 <= ret_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
module tb_rf_arbiter;
    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1, WR0, WR1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       GNT0, GNT1;
    logic [7:0] RDATA0, RDATA1;
    logic       RVALID0, RVALID1, RERR0, RERR1;
    logic       RF_WrEn, RF_RdEn;
    logic [3:0] RF_Address;
    logic [7:0] RF_Wr_D;
    logic [7:0] RF_Rd_D;
    logic       RF_Rd_D_Valid;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: whether a read is pending, who owns it,
    // how long it has waited, who was served last, and what the next cycle must show.
    bit         m_busy;
    bit         m_owner;
    int         m_wait;
    bit         m_last;
    bit         e_wren, e_rden;
    logic [3:0] e_addr;
    logic [7:0] e_wrd;
    logic [7:0] e_rdata [2];
    bit         e_rvalid [2];
    bit         e_rerr [2];

    rf_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RVALID0(RVALID0), .RVALID1(RVALID1), .RERR0(RERR0), .RERR1(RERR1),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_Wr_D(RF_Wr_D), .RF_Rd_D(RF_Rd_D), .RF_Rd_D_Valid(RF_Rd_D_Valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_wait  = 0;
        m_last  = 1;
        e_wren  = 0;
        e_rden  = 0;
        e_addr  = '0;
        e_wrd   = '0;
        for (int i = 0; i < 2; i++) begin
            e_rdata[i]  = '0;
            e_rvalid[i] = 0;
            e_rerr[i]   = 0;
        end
    endtask

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        RF_Rd_D = '0; RF_Rd_D_Valid = 0;
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    // It checks the outputs, advances the reference and consumes one clock cycle.
    task automatic tick();
        int g;
        #1;
        if (!RST) model_reset();
        chk("rf_wren",  RF_WrEn,    e_wren);
        chk("rf_rden",  RF_RdEn,    e_rden);
        chk("rf_addr",  RF_Address, e_addr);
        chk("rf_wr_d",  RF_Wr_D,    e_wrd);
        chk("rdata0",   RDATA0,     e_rdata[0]);
        chk("rdata1",   RDATA1,     e_rdata[1]);
        chk("rvalid0",  RVALID0,    e_rvalid[0]);
        chk("rvalid1",  RVALID1,    e_rvalid[1]);
        chk("rerr0",    RERR0,      e_rerr[0]);
        chk("rerr1",    RERR1,      e_rerr[1]);
        g = -1;
        if (RST && !m_busy) begin
            if (REQ0 && REQ1) g = m_last ? 0 : 1;
            else if (REQ0)    g = 0;
            else if (REQ1)    g = 1;
        end
        chk("gnt0", GNT0, g == 0);
        chk("gnt1", GNT1, g == 1);
        if (RST) begin
            e_wren = 0;
            e_rden = 0;
            for (int i = 0; i < 2; i++) begin
                e_rvalid[i] = 0;
                e_rerr[i]   = 0;
            end
            if (m_busy) begin
                m_wait++;
                if (RF_Rd_D_Valid) begin
                    e_rvalid[m_owner] = 1;
                    e_rdata[m_owner]  = RF_Rd_D;
                    m_busy = 0;
                end else if (m_wait == TO) begin
                    e_rvalid[m_owner] = 1;
                    e_rerr[m_owner]   = 1;
                    e_rdata[m_owner]  = '0;
                    m_busy = 0;
                end
            end else if (g >= 0) begin
                m_last = (g == 1);
                e_addr = (g == 1) ? ADDR1 : ADDR0;
                if ((g == 1) ? WR1 : WR0) begin
                    e_wren = 1;
                    e_wrd  = (g == 1) ? WDATA1 : WDATA0;
                end else begin
                    e_rden  = 1;
                    m_busy  = 1;
                    m_owner = (g == 1);
                    m_wait  = 0;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        RST = 1;
        #1 RST = 0;
        @(negedge CLK);

        // Reset held with a request present: no grant, all outputs 0.
        REQ0 = 1; WR0 = 1;
        tick();
        tick();
        idle_inputs();
        RST = 1;
        tick();

        // Single write.
        REQ0 = 1; WR0 = 1; ADDR0 = 4'h3; WDATA0 = 8'h5A;
        #1 chk("wr_gnt0", GNT0, 1'b1);
        tick();
        idle_inputs();
        chk("wr_strobe", RF_WrEn, 1'b1);
        chk("wr_addr", RF_Address, 4'h3);
        chk("wr_data", RF_Wr_D, 8'h5A);
        tick();
        chk("wr_strobe_end", RF_WrEn, 1'b0);
        tick();

        // Read by requester 1, data returned one cycle after the strobe.
        REQ1 = 1; WR1 = 0; ADDR1 = 4'h2;
        tick();
        idle_inputs();
        chk("rd_strobe", RF_RdEn, 1'b1);
        chk("rd_addr", RF_Address, 4'h2);
        tick();
        RF_Rd_D_Valid = 1; RF_Rd_D = 8'hC3;
        tick();
        RF_Rd_D_Valid = 0;
        chk("rd_rvalid1", RVALID1, 1'b1);
        chk("rd_rdata1", RDATA1, 8'hC3);
        chk("rd_rvalid0", RVALID0, 1'b0);
        tick();

        // Contention with writes: alternate grants starting with requester 0.
        REQ0 = 1; WR0 = 1; ADDR0 = 4'h1; WDATA0 = 8'h11;
        REQ1 = 1; WR1 = 1; ADDR1 = 4'h8; WDATA1 = 8'h88;
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_gnt1", GNT1, (i % 2) == 1);
            tick();
        end
        idle_inputs();
        tick();

        // Timeout: requester 0 reads with no data returned, requester 1 write pending.
        REQ0 = 1; WR0 = 0; ADDR0 = 4'h7;
        REQ1 = 1; WR1 = 1; ADDR1 = 4'h9; WDATA1 = 8'h99;
        tick();
        REQ0 = 0;
        for (int i = 0; i < TO; i++) tick();
        chk("to_rvalid0", RVALID0, 1'b1);
        chk("to_rerr0", RERR0, 1'b1);
        chk("to_rdata0", RDATA0, 8'h00);
        #1 chk("to_gnt1", GNT1, 1'b1);
        tick();
        idle_inputs();
        tick();

        // Stray valid in IDLE produces nothing.
        RF_Rd_D_Valid = 1; RF_Rd_D = 8'h3C;
        tick();
        RF_Rd_D_Valid = 0;
        tick();

        // Reset during RD_WAIT discards the read.
        REQ0 = 1; WR0 = 0; ADDR0 = 4'h5;
        tick();
        idle_inputs();
        tick();
        RST = 0;
        tick();
        RST = 1;
        RF_Rd_D_Valid = 1; RF_Rd_D = 8'hAA;
        tick();
        RF_Rd_D_Valid = 0;
        chk("rst_no_rvalid0", RVALID0, 1'b0);
        tick();
        tick();

        // Random traffic against the reference.
        for (int n = 0; n < 600; n++) begin
            RST           = ($urandom_range(0, 99) != 0);
            REQ0          = ($urandom_range(0, 99) < 55);
            REQ1          = ($urandom_range(0, 99) < 55);
            WR0           = $urandom_range(0, 1);
            WR1           = $urandom_range(0, 1);
            ADDR0         = 4'($urandom);
            ADDR1         = 4'($urandom);
            WDATA0        = 8'($urandom);
            WDATA1        = 8'($urandom);
            RF_Rd_D       = 8'($urandom);
            RF_Rd_D_Valid = ($urandom_range(0, 99) < 15);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Shares the single-port register file between two requesters: requester 0 is the system command controller and requester 1 is an auxiliary configuration/debug master.
- Each requester has a valid/grant handshake. Round-robin arbitration selects between them.
- The arbiter drives the register-file strobes and routes read data back to the requester that issued the read.
- At most one read is outstanding at a time, and a read timeout prevents lock-up.

Parameters:
- ADDR_W, 4: register-file address width.
- DATA_W, 8: data width.
- TIMEOUT, 8: maximum cycles spent in RD_WAIT before the read is aborted (range 2..255).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- REQ0, REQ1  in  1  request valid, held until granted
- WR0, WR1  in  1  1 = write, 0 = read
- ADDR0, ADDR1  in  ADDR_W  target address
- WDATA0, WDATA1  in  DATA_W  write data
- GNT0, GNT1  out  1  grant (combinational); the transfer occurs at the rising edge where REQx && GNTx
- RDATA0, RDATA1  out  DATA_W  returned read data (registered)
- RVALID0, RVALID1  out  1  one-cycle read-return pulse
- RERR0, RERR1  out  1  one-cycle pulse, coincident with RVALIDx, on timeout
- RF_WrEn  out  1  register-file write strobe
- RF_RdEn  out  1  register-file read strobe
- RF_Address  out  ADDR_W  register-file address
- RF_Wr_D  out  DATA_W  register-file write data
- RF_Rd_D  in  DATA_W  register-file read data
- RF_Rd_D_Valid  in  1  register-file read data valid

Behaviour:
- Reset: state = IDLE, round-robin pointer = "last granted 1" (requester 0 wins first), timeout counter = 0.
  - All registered outputs are 0: RF_WrEn, RF_RdEn, RF_Address, RF_Wr_D, RDATAx, RVALIDx, RERRx.
  - GNTx = 0 while RST is low.
- States:
  - IDLE: accepts requests.
  - RD_WAIT: a read is outstanding and the owner ID is latched.
- Arbitration, in IDLE only:
  - If one REQ is high, that requester is granted.
  - If both are high, the requester not granted most recently is granted.
  - Exactly one GNT is high, or none.
  - In RD_WAIT both GNTs are 0.
- Transfer at edge E (REQx && GNTx):
  - The pointer updates to x.
  - In cycle E+1, RF_Address = ADDRx.
  - Write: RF_WrEn = 1 and RF_Wr_D = WDATAx in cycle E+1. State stays IDLE, so back-to-back writes are possible, one per cycle.
  - Read: RF_RdEn = 1 in cycle E+1, the owner is latched as x, the state becomes RD_WAIT and the counter is cleared.
- Strobes last exactly one cycle. RF_Address and RF_Wr_D hold their last values when no strobe is active.
- RD_WAIT:
  - The counter increments each cycle.
  - The first cycle with RF_Rd_D_Valid = 1 captures the data. In the next cycle, RDATAowner = RF_Rd_D, RVALIDowner = 1 and the state returns to IDLE.
  - Grants resume in the cycle in which RVALID is high.
  - The counter reaching TIMEOUT with no valid aborts the read. In the next cycle, RDATAowner = 0, RVALIDowner = 1, RERRowner = 1 and the state returns to IDLE.
  - If valid and timeout occur in the same cycle, valid wins and RERR = 0.
- RF_Rd_D_Valid while in IDLE is ignored: no RVALID is produced.
- RDATAx holds its last value between returns. The non-owner's RVALID and RERR stay 0.
- A requester dropping REQ before it is granted withdraws the request, and no transfer occurs.
- Reset mid-operation: an outstanding read is discarded, with no RVALID after reset deassertion.

Test Plan:
- Single write: REQ0 = 1, WR0 = 1, ADDR0 = 4'h3, WDATA0 = 8'h5A.
  - Required: GNT0 = 1 the same cycle, then RF_WrEn = 1, RF_Address = 3, RF_Wr_D = 8'h5A for exactly one cycle; GNT1 = 0 throughout.
- Read with 1-cycle RF latency: REQ1 read of ADDR1 = 4'h2; the register file returns 8'hC3 with Rd_D_Valid one cycle after RF_RdEn.
  - Required: RVALID1 = 1 and RDATA1 = 8'hC3 one cycle later; RVALID0 = 0; GNTx = 0 throughout RD_WAIT.
- Contention: REQ0 and REQ1 both held high with writes for 4 cycles after reset.
  - Required: grant order 0, 1, 0, 1; RF_Address alternates ADDR0/ADDR1.
- Timeout: REQ0 read of 4'h7 with RF_Rd_D_Valid tied to 0 and TIMEOUT = 8.
  - Required: RVALID0 = 1, RERR0 = 1, RDATA0 = 8'h00 after timeout; a pending REQ1 is granted in the following cycle.
- Stray valid and reset abort:
  - RF_Rd_D_Valid pulsed while in IDLE -> no RVALIDx.
  - RST pulsed low during RD_WAIT -> all outputs 0; no RVALID appears after release, even if Rd_D_Valid then arrives.
